// File: rtl/alu_pipeline_if.sv
// Instruction-in / writeback-out handshake bundle for alu_pipeline.
// The master drives instructions and accepts results; the slave is the datapath.
interface alu_pipeline_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned OpW   = 4
);
  localparam int unsigned AW = $clog2(NREGS);

  logic            in_valid;
  logic            in_ready;
  logic [OpW-1:0]  in_op;
  logic [AW-1:0]   in_dst;
  logic [AW-1:0]   in_src1;
  logic [AW-1:0]   in_src2;
  logic            in_use_imm;
  logic [XLEN-1:0] in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_dst;
  logic [XLEN-1:0] out_data;

  modport master (
    output in_valid, in_op, in_dst, in_src1, in_src2, in_use_imm, in_imm, out_ready,
    input  in_ready, out_valid, out_dst, out_data
  );

  modport slave (
    input  in_valid, in_op, in_dst, in_src1, in_src2, in_use_imm, in_imm, out_ready,
    output in_ready, out_valid, out_dst, out_data
  );
endinterface

// File: rtl/alu_pipeline.sv
// Two-stage (EX, WB) execution datapath: register file, ALU, full operand forwarding,
// valid/ready on both ends, in-order retirement.
package alu_pipeline_pkg;
  typedef enum logic [3:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra, OpSlt, OpSltu
  } alu_op_e;
endpackage

module alu_pipeline
  import alu_pipeline_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  alu_pipeline_if.slave              bus,
  input  logic [$clog2(NREGS)-1:0]   dbg_addr,
  output logic [XLEN-1:0]            dbg_data
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned SW = $clog2(XLEN);

  logic [XLEN-1:0] r_rf [NREGS];

  logic            r_ex_valid;
  alu_op_e         r_ex_op;
  logic [AW-1:0]   r_ex_dst;
  logic [XLEN-1:0] r_ex_a;
  logic [XLEN-1:0] r_ex_b;

  logic            r_wb_valid;
  logic [AW-1:0]   r_wb_dst;
  logic [XLEN-1:0] r_wb_data;

  logic            w_stall;
  logic            w_accept;
  logic            w_retire;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_src2;
  logic [XLEN-1:0] w_op_b;
  logic [SW-1:0]   w_shamt;

  // Youngest producer wins: EX result beats WB result beats the register file.
  function automatic logic [XLEN-1:0] f_resolve(
    input logic [AW-1:0]   src,
    input logic            ex_v,
    input logic [AW-1:0]   ex_d,
    input logic [XLEN-1:0] ex_r,
    input logic            wb_v,
    input logic [AW-1:0]   wb_d,
    input logic [XLEN-1:0] wb_r,
    input logic [XLEN-1:0] rf_v
  );
    logic [XLEN-1:0] val;
    if (src == '0)                   val = '0;
    else if (ex_v && (ex_d == src))  val = ex_r;
    else if (wb_v && (wb_d == src))  val = wb_r;
    else                             val = rf_v;
    return val;
  endfunction

  assign w_stall      = r_wb_valid & ~bus.out_ready;
  assign bus.in_ready = ~rst & ~w_stall;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_retire     = r_wb_valid & bus.out_ready;

  assign bus.out_valid = r_wb_valid;
  assign bus.out_dst   = r_wb_dst;
  assign bus.out_data  = r_wb_data;

  assign dbg_data = r_rf[dbg_addr];

  always_comb begin
    w_op_a = f_resolve(bus.in_src1, r_ex_valid, r_ex_dst, w_alu,
                       r_wb_valid, r_wb_dst, r_wb_data, r_rf[bus.in_src1]);
    w_src2 = f_resolve(bus.in_src2, r_ex_valid, r_ex_dst, w_alu,
                       r_wb_valid, r_wb_dst, r_wb_data, r_rf[bus.in_src2]);
    w_op_b = bus.in_use_imm ? bus.in_imm : w_src2;
  end

  always_comb begin
    w_shamt = r_ex_b[SW-1:0];
    w_alu   = '0;
    case (r_ex_op)
      OpAdd:   w_alu = r_ex_a + r_ex_b;
      OpSub:   w_alu = r_ex_a - r_ex_b;
      OpAnd:   w_alu = r_ex_a & r_ex_b;
      OpOr:    w_alu = r_ex_a | r_ex_b;
      OpXor:   w_alu = r_ex_a ^ r_ex_b;
      OpSll:   w_alu = r_ex_a << w_shamt;
      OpSrl:   w_alu = r_ex_a >> w_shamt;
      OpSra:   w_alu = $unsigned($signed(r_ex_a) >>> w_shamt);
      OpSlt:   w_alu = {{(XLEN-1){1'b0}}, ($signed(r_ex_a) < $signed(r_ex_b))};
      OpSltu:  w_alu = {{(XLEN-1){1'b0}}, (r_ex_a < r_ex_b)};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= OpAdd;
      r_ex_dst   <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_wb_valid <= 1'b0;
      r_wb_dst   <= '0;
      r_wb_data  <= '0;
    end else if (!w_stall) begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_op  <= alu_op_e'(bus.in_op);
        r_ex_dst <= bus.in_dst;
        r_ex_a   <= w_op_a;
        r_ex_b   <= w_op_b;
      end
      r_wb_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_wb_dst  <= r_ex_dst;
        r_wb_data <= w_alu;
      end
    end
  end

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_retire && (r_wb_dst != '0)) begin
      r_rf[r_wb_dst] <= r_wb_data;
    end
  end
endmodule

// File: tb/tb_alu_pipeline.sv
// Directed bench for alu_pipeline: forwarding chains, register mode, backpressure,
// r0 handling, wrap-around, ALU op mix and asynchronous mid-flight reset.
module tb_alu_pipeline;
  import alu_pipeline_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  alu_op_e         p_op   [16];
  logic [AW-1:0]   p_dst  [16];
  logic [AW-1:0]   p_s1   [16];
  logic [AW-1:0]   p_s2   [16];
  logic            p_isel [16];
  logic [XLEN-1:0] p_imm  [16];
  logic [XLEN-1:0] e_data [16];
  int              n_prog;

  alu_pipeline_if #(.XLEN(XLEN), .NREGS(NREGS), .OpW(4)) bus ();

  alu_pipeline #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input alu_op_e op, input int dst, input int s1, input int s2,
                     input logic isel, input logic [XLEN-1:0] imm, input logic [XLEN-1:0] exp);
    p_op[n_prog]   = op;
    p_dst[n_prog]  = AW'(dst);
    p_s1[n_prog]   = AW'(s1);
    p_s2[n_prog]   = AW'(s2);
    p_isel[n_prog] = isel;
    p_imm[n_prog]  = imm;
    e_data[n_prog] = exp;
    n_prog++;
  endtask

  task automatic drive(input int i);
    bus.in_valid   = 1'b1;
    bus.in_op      = p_op[i];
    bus.in_dst     = p_dst[i];
    bus.in_src1    = p_s1[i];
    bus.in_src2    = p_s2[i];
    bus.in_use_imm = p_isel[i];
    bus.in_imm     = p_imm[i];
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic dbg_chk(input int addr, input logic [XLEN-1:0] exp);
    dbg_addr = AW'(addr);
    #1;
    chk($sformatf("dbg_r%0d", addr), dbg_data, exp);
  endtask

  // Issue the program back to back with out_ready high; results must appear one per
  // cycle starting two edges after the first accept.
  task automatic run_burst(input string tag);
    bus.out_ready = 1'b1;
    for (int c = 0; c <= n_prog; c++) begin
      if (c < n_prog) drive(c);
      else idle();
      #1;
      if (c < n_prog) chk($sformatf("%s_in_ready[%0d]", tag, c), bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      if (c == 0) begin
        chk($sformatf("%s_latency_valid", tag), bus.out_valid, 1'b0);
      end else begin
        chk($sformatf("%s_valid[%0d]", tag, c - 1), bus.out_valid, 1'b1);
        chk($sformatf("%s_dst[%0d]", tag, c - 1), bus.out_dst, p_dst[c-1]);
        chk($sformatf("%s_data[%0d]", tag, c - 1), bus.out_data, e_data[c-1]);
      end
    end
    idle();
    @(posedge clk);
    #1;
    chk($sformatf("%s_drained", tag), bus.out_valid, 1'b0);
  endtask

  // out_ready low for cycles 0..4: two accepts fill the pipe, then three stall cycles.
  task automatic run_bp();
    int  issued  = 0;
    int  retired = 0;
    logic fire_in;
    logic fire_out;
    for (int c = 0; c < 60 && retired < n_prog; c++) begin
      bus.out_ready = (c >= 5);
      if (issued < n_prog) drive(issued);
      else idle();
      #1;
      if (c >= 2 && c <= 4) begin
        chk($sformatf("bp_in_ready[%0d]", c), bus.in_ready, 1'b0);
        chk($sformatf("bp_hold_valid[%0d]", c), bus.out_valid, 1'b1);
        chk($sformatf("bp_hold_dst[%0d]", c), bus.out_dst, 5'd1);
        chk($sformatf("bp_hold_data[%0d]", c), bus.out_data, 32'd10);
      end
      fire_in  = bus.in_valid & bus.in_ready;
      fire_out = bus.out_valid & bus.out_ready;
      if (fire_out) begin
        chk($sformatf("bp_ret_dst[%0d]", retired), bus.out_dst, p_dst[retired]);
        chk($sformatf("bp_ret_data[%0d]", retired), bus.out_data, e_data[retired]);
        retired++;
      end
      @(posedge clk);
      #1;
      if (fire_in) issued++;
    end
    chk("bp_retired_count", retired, n_prog);
    idle();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_no_extra", bus.out_valid, 1'b0);
  endtask

  task automatic load_chain();
    n_prog = 0;
    add(OpAdd, 1, 0, 0, 1'b1, 32'd10, 32'd10);
    add(OpSll, 1, 1, 0, 1'b1, 32'd3,  32'd80);
    add(OpAdd, 2, 1, 0, 1'b1, 32'd1,  32'd81);
    add(OpAdd, 3, 2, 0, 1'b1, 32'd1,  32'd82);
    add(OpAdd, 4, 3, 0, 1'b1, 32'd1,  32'd83);
    add(OpAdd, 5, 4, 0, 1'b1, 32'd1,  32'd84);
  endtask

  initial begin
    rst            = 1'b1;
    dbg_addr       = '0;
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_dst     = '0;
    bus.in_src1    = '0;
    bus.in_src2    = '0;
    bus.in_use_imm = 1'b0;
    bus.in_imm     = '0;
    bus.out_ready  = 1'b1;
    n_prog         = 0;

    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_dst", bus.out_dst, '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_dbg_r0", dbg_data, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    load_chain();
    run_burst("chain");
    dbg_chk(1, 32'd80);
    dbg_chk(2, 32'd81);
    dbg_chk(3, 32'd82);
    dbg_chk(4, 32'd83);
    dbg_chk(5, 32'd84);

    n_prog = 0;
    add(OpSub, 6, 2, 1, 1'b0, 32'd0, 32'd1);
    add(OpAdd, 7, 6, 6, 1'b0, 32'd0, 32'd2);
    run_burst("regmode");

    load_chain();
    run_bp();
    dbg_chk(5, 32'd84);

    n_prog = 0;
    add(OpAdd, 0, 0, 0, 1'b1, 32'd55, 32'd55);
    add(OpAdd, 8, 0, 0, 1'b1, 32'd1,  32'd1);
    run_burst("r0");
    dbg_chk(0, 32'd0);
    dbg_chk(8, 32'd1);

    n_prog = 0;
    add(OpAdd, 9,  0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add(OpAdd, 10, 9, 0, 1'b1, 32'd1,         32'd0);
    run_burst("wrap");

    n_prog = 0;
    add(OpAdd,  13, 0,  0,  1'b1, 32'h0F0, 32'h0000_00F0);
    add(OpXor,  14, 13, 0,  1'b1, 32'h0FF, 32'h0000_000F);
    add(OpAnd,  15, 13, 0,  1'b1, 32'h03C, 32'h0000_0030);
    add(OpOr,   16, 13, 0,  1'b1, 32'h00F, 32'h0000_00FF);
    add(OpSrl,  17, 9,  0,  1'b1, 32'd36,  32'h0FFF_FFFF);
    add(OpSra,  18, 9,  0,  1'b1, 32'd4,   32'hFFFF_FFFF);
    add(OpSlt,  19, 9,  0,  1'b0, 32'd0,   32'd1);
    add(OpSltu, 20, 9,  13, 1'b0, 32'd0,   32'd0);
    add(OpSub,  21, 0,  13, 1'b0, 32'd0,   32'hFFFF_FF10);
    add(OpSll,  22, 14, 0,  1'b1, 32'd33,  32'h0000_001E);
    run_burst("ops");

    n_prog = 0;
    add(OpAdd, 11, 0, 0, 1'b1, 32'd5, 32'd5);
    add(OpAdd, 12, 0, 0, 1'b1, 32'd6, 32'd6);
    bus.out_ready = 1'b1;
    drive(0);
    @(posedge clk);
    #1;
    drive(1);
    @(posedge clk);
    #1;
    idle();
    chk("inflight_valid", bus.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 1'b0);
    chk("async_rst_in_ready", bus.in_ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 32; r++) dbg_chk(r, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_nothing_retires", bus.out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_pipeline.md
# alu_pipeline

Parametrised, pipelined execution datapath: register file, ALU and a two-stage issue/execute/writeback pipeline with full operand forwarding and a valid/ready handshake on both the instruction input and the writeback output. It accepts one instruction per clock, selects the second operand from either a register or an immediate, and retires results in order. It is the next-generation core datapath and sits between the future fetch/decode front end and the writeback consumer (trace/commit logic).

## Interface

- XLEN, 32: data and register width in bits.
- NREGS, 32: number of architectural registers; power of two, at least 2. AW = clog2(NREGS).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  instruction accepted when in_valid and in_ready are both high at a rising edge.
- in_op  in  AluOp  ALU operation (AluOp enum from the types package).
- in_dst  in  AW  destination register.
- in_src1  in  AW  first source register.
- in_src2  in  AW  second source register; used when in_use_imm is 0.
- in_use_imm  in  1  1 selects in_imm as operand 2; 0 selects register in_src2.
- in_imm  in  XLEN  immediate operand.
- out_valid  out  1  writeback result present.
- out_ready  in  1  consumer accepts the result.
- out_dst  out  AW  destination of the presented result.
- out_data  out  XLEN  presented result.
- dbg_addr  in  AW  debug register-file read address.
- dbg_data  out  XLEN  combinational register-file contents at dbg_addr; pending writeback is not included.

## Operation

- Stages: EX register (valid, op, dst, operand A, operand B) and WB register (valid, dst, result).
- Accept: operands are resolved combinationally in the accept cycle and captured into EX.
- Operand resolution for each register source, highest priority first:
  - register 0 reads 0;
  - EX stage valid with matching dst: the current ALU output;
  - WB stage valid with matching dst: the WB result;
  - otherwise the register-file value.
- Execute: the ALU computes from the EX operands. The result is captured into WB on the next advancing edge.
- Retire:
  - the result is written to the register file on the edge where out_valid and out_ready are both high;
  - writes to register 0 are discarded, but the result is still presented on out_*.
- ALU arithmetic is modulo 2^XLEN. Shift amounts use the low clog2(XLEN) bits of operand B.
- Stall:
  - stall = out_valid and not out_ready;
  - on a stall, EX and WB hold and in_ready is 0;
  - otherwise the pipeline advances every cycle, and bubbles propagate as valid = 0.
- Ordering: results retire strictly in issue order. No instruction is dropped or duplicated.

## Timing

- Reset (asynchronous):
  - all registers, EX and WB contents are cleared to 0;
  - both valid bits are cleared;
  - out_valid = 0, out_dst = 0, out_data = 0.
  - in_ready is 1 while rst is low and the pipe is not stalled; in_ready is 0 while rst is high.
- Latency: an instruction accepted at edge N has out_valid = 1 after edge N+1 (2 cycles), assuming no stall.
- Throughput: 1 instruction per cycle with out_ready held high.
- Back-to-back dependency (distance 1 or 2) incurs zero stall cycles through forwarding.
- Simultaneous retire and accept that read the retiring register: the WB forward supplies the value, so the register-file write timing is irrelevant.
- Stall release: on the first cycle out_ready = 1, the WB result retires, the pipe advances, and in_ready = 1 in that same cycle.
- out_* are stable while out_valid = 1 and out_ready = 0.
- Reset asserted mid-flight: in-flight instructions are discarded and nothing retires. Register-file writes already committed are cleared as well.

## Test plan

- Forwarding chain, out_ready = 1, immediate mode, issued on consecutive cycles:
  - r1 = r0 + 10
  - r1 = r1 SHL 3
  - r2 = r1 + 1
  - r3 = r2 + 1
  - r4 = r3 + 1
  - r5 = r4 + 1
  - Required: out_data sequence 10, 80, 81, 82, 83, 84, one per cycle, starting 2 cycles after the first accept. dbg_data afterwards shows r1..r5 = 80, 81, 82, 83, 84.
- Register mode: with r1 = 80 and r2 = 81, issue r6 = r2 SUB r1 (in_use_imm = 0) followed immediately by r7 = r6 ADD r6. Required: results 1, then 2.
- Backpressure:
  - hold out_ready = 0 for 3 cycles while the r1..r5 chain is issued;
  - required: in_ready = 0 during the stall and out_* frozen;
  - after release, the same value sequence appears with no loss or duplication.
- r0 handling:
  - r0 = r0 + 55 is presented with out_dst = 0 and out_data = 55;
  - a following r8 = r0 + 1 yields 1, and dbg_data at address 0 reads 0.
- Wrap-around: with XLEN = 32 and r9 = 0xFFFFFFFF, r9 + 1 yields 0.
- Reset:
  - assert rst asynchronously (off the clock edge) while two instructions are in flight;
  - required: out_valid drops immediately, nothing retires, and all registers read 0 via dbg after release.
